// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 pin bundle for ps2_host_tx.
// master = system side (drives tx_data/tx_start and raw pins), slave = transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack;
  logic       tx_err;
  logic       ps2k_clk;
  logic       ps2k_data;
  logic       ps2k_clk_oe;
  logic       ps2k_data_oe;

  modport master (
    output tx_data,
    output tx_start,
    output ps2k_clk,
    output ps2k_data,
    input  tx_busy,
    input  tx_done,
    input  tx_ack,
    input  tx_err,
    input  ps2k_clk_oe,
    input  ps2k_data_oe
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    input  ps2k_clk,
    input  ps2k_data,
    output tx_busy,
    output tx_done,
    output tx_ack,
    output tx_err,
    output ps2k_clk_oe,
    output ps2k_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Ports: clk, rst_n (sync active-low); bus (slave): tx_data/tx_start in,
//   tx_busy/tx_done/tx_ack/tx_err out, raw ps2k_clk/ps2k_data in,
//   ps2k_clk_oe/ps2k_data_oe out (1 = pull line low).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned CNT_W       = 20
) (
  input logic         clk,
  input logic         rst_n,
  ps2_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state;
  logic [2:0]       clk_sy;
  logic [1:0]       dat_sy;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       byte_q;
  logic [3:0]       idx;
  logic             ack_q;

  logic clk_oe;
  logic data_oe;
  logic busy;
  logic done;
  logic ack;
  logic err;

  logic clk_s;
  logic dat_s;
  logic fall;
  logic bus_idle;
  logic timed;
  logic abort;
  logic bit_cur;

  assign clk_s    = clk_sy[1];
  assign dat_s    = dat_sy[1];
  assign fall     = clk_sy[2] & ~clk_sy[1];
  assign bus_idle = clk_s & dat_s;

  assign timed = (state == S_SEND) ||
                 (state == S_ACK)  ||
                 (state == S_WAIT);

  // A device edge restarts the window, and a released bus in
  // WAIT completes the transfer, so neither may race the timeout.
  assign abort = timed && !fall &&
                 (cnt == TO_LAST) &&
                 !((state == S_WAIT) && bus_idle);

  // Frame after the start bit: 8 data LSB first, odd parity, stop.
  always_comb begin
    bit_cur = 1'b1;
    if (idx < 4'd8)
      bit_cur = byte_q[idx[2:0]];
    else if (idx == 4'd8)
      bit_cur = ~^byte_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clk_sy  <= '1;
      dat_sy  <= '1;
      cnt     <= '0;
      byte_q  <= '0;
      idx     <= '0;
      ack_q   <= 1'b0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      clk_sy <= {clk_sy[1:0], bus.ps2k_clk};
      dat_sy <= {dat_sy[0], bus.ps2k_data};
      done   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;

      if (abort) begin
        clk_oe  <= 1'b0;
        data_oe <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
        err     <= 1'b1;
        cnt     <= '0;
        state   <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            cnt     <= '0;
            if (bus.tx_start) begin
              byte_q <= bus.tx_data;
              clk_oe <= 1'b1;
              busy   <= 1'b1;
              state  <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (cnt == INH_LAST) begin
              data_oe <= 1'b1;
              cnt     <= '0;
              state   <= S_REQ;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          S_REQ: begin
            clk_oe <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            state  <= S_SEND;
          end

          S_SEND: begin
            if (fall) begin
              data_oe <= ~bit_cur;
              idx     <= idx + 4'd1;
              cnt     <= '0;
              if (idx == 4'd9)
                state <= S_ACK;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          S_ACK: begin
            if (fall) begin
              ack_q <= ~dat_s;
              cnt   <= '0;
              state <= S_WAIT;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          S_WAIT: begin
            if (bus_idle) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              ack   <= ack_q;
              err   <= ~ack_q;
              cnt   <= '0;
              state <= S_IDLE;
            end else if (fall) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          default: begin
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ps2k_clk_oe  = clk_oe;
  assign bus.ps2k_data_oe = data_oe;
  assign bus.tx_busy      = busy;
  assign bus.tx_done      = done;
  assign bus.tx_ack       = ack;
  assign bus.tx_err       = err;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED LED set, 0xFF reset) from the FPGA to the attached keyboard using the standard host request-to-send sequence. Drives the shared open-drain PS/2 clock and data lines and reports acknowledge or failure. During a transfer it asserts `tx_busy` so the keyboard scan receiver can ignore host-generated edges.

## Interface
- `INHIBIT_CYC`, default 5000: cycles the host holds PS/2 clock low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYC`, default 750000: maximum cycles between device clock falling edges, and in WAIT_IDLE (15 ms at 50 MHz).
- `CNT_W`, default 20: width of the cycle counter; must hold `max(INHIBIT_CYC, TIMEOUT_CYC)`.

- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `tx_data` in 8: command byte; sampled when `tx_start` is accepted.
- `tx_start` in 1: request pulse; accepted only in IDLE.
- `ps2k_clk` in 1: raw PS/2 clock line (asynchronous).
- `ps2k_data` in 1: raw PS/2 data line (asynchronous).
- `ps2k_clk_oe` out 1: 1 = pull PS/2 clock low; 0 = release.
- `ps2k_data_oe` out 1: 1 = pull PS/2 data low; 0 = release.
- `tx_busy` out 1: high from the cycle after acceptance until the return to IDLE.
- `tx_done` out 1: one-cycle pulse when a transfer ends, successful or not.
- `tx_ack` out 1: device acknowledge seen; valid while `tx_done` = 1.
- `tx_err` out 1: timeout or no acknowledge; valid while `tx_done` = 1.

## Operation
- Input conditioning:
  - `ps2k_clk` and `ps2k_data` each pass through a 2-flop synchronizer.
  - A third flop on the synced clock gives fall = prev & ~cur.
- Parity bit = ~^byte (odd parity).
- States:
  - IDLE: both OE = 0, counter cleared. On `tx_start`, latch `tx_data` and go to INHIBIT.
  - INHIBIT: `ps2k_clk_oe` = 1. Counts INHIBIT_CYC cycles. On terminal count, set `ps2k_data_oe` = 1 (start bit) and go to REQ.
  - REQ: exactly 1 cycle with both OE = 1. Next cycle, `ps2k_clk_oe` = 0; clear counter; go to SEND with bit index 0.
  - SEND: on each fall, drive bit[idx] with `ps2k_data_oe` = ~bit, then idx++.
    - idx 0–7: data bits, LSB first.
    - idx 8: parity bit.
    - idx 9: stop bit (`ps2k_data_oe` = 0); go to ACK.
  - ACK: on the next fall, sample synced data. `ack` = ~data. Go to WAIT_IDLE.
  - WAIT_IDLE: when synced clock and data are both 1, pulse `tx_done`. Set `tx_ack` = ack and `tx_err` = ~ack, then go to IDLE.
- Timeout:
  - The counter clears on entry to SEND and on every fall in SEND, ACK and WAIT_IDLE.
  - If it reaches TIMEOUT_CYC in any of these states, both OE go to 0 and `tx_done` = 1, `tx_err` = 1, `tx_ack` = 0. Return to IDLE.
- `tx_start` while not in IDLE is ignored; `tx_data` changes after acceptance have no effect.
- Reset (`rst_n` = 0 at a rising edge, including mid-transfer):
  - Next state is IDLE.
  - All outputs 0: both OE = 0, `tx_busy`/`tx_done`/`tx_ack`/`tx_err` = 0.
  - Synchronizer flops preset to 1 (idle bus).
  - A transfer interrupted by reset produces no `tx_done`.

## Timing
- From the `tx_start` cycle:
  - `tx_busy` and `ps2k_clk_oe` rise at the next edge.
  - `ps2k_data_oe` rises INHIBIT_CYC cycles after `ps2k_clk_oe`.
  - `ps2k_clk_oe` falls 1 cycle after `ps2k_data_oe` rises.
- A device clock falling edge is detected 3 `clk` cycles after the pin transition. The data OE update occurs on the cycle after detection, well inside the device's low phase (≥30 µs).
- `tx_done`, `tx_ack` and `tx_err` are registered and asserted together for exactly one cycle. `tx_busy` falls in the same cycle as `tx_done`.
- A back-to-back `tx_start` is accepted in the cycle after `tx_done`.
- Total transfer: INHIBIT_CYC + 1 + 11 device clock periods + bus-idle wait.

## Test plan
- Bench setup: INHIBIT_CYC = 20, TIMEOUT_CYC = 200, device model clocking at 40-cycle period, ACK enabled.
- `tx_data` = 0xED → clock held low 20 cycles, then data low. Data sampled on device rising edges reads 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK low → `tx_done` = 1, `tx_ack` = 1, `tx_err` = 0.
- `tx_data` = 0x07 → parity bit 0. `tx_data` = 0x00 → parity bit 1. Both end with `tx_ack` = 1.
- Device never clocks after the request → `tx_done` = 1 and `tx_err` = 1 exactly 200 cycles after `ps2k_clk_oe` falls. Both OE = 0.
- Device leaves data high during the ACK clock → `tx_done` = 1, `tx_ack` = 0, `tx_err` = 1.
- Second `tx_start` with 0x55 during a 0xF4 transfer → ignored; the bits on the line match 0xF4.
- `rst_n` = 0 at bit 4 → next cycle both OE = 0, `tx_busy` = 0, no `tx_done`. A following `tx_start` completes normally.
